// File: rtl/player_weapon_ctrl.sv
// -----------------------------------------------------------------------------
// player_weapon_ctrl
//
// Player-side weapon controller. Conditions the rotate/fire push-buttons,
// tracks a 16-sector aim angle, and issues a single-cycle projectile strobe
// carrying the latched weapon type. Each weapon type has its own cooldown;
// the precise weapon (type 11) additionally consumes a limited charge that
// only reset refills.
//
// Ports
//   clk                   system clock
//   reset                 asynchronous active-high reset; release must already
//                         be synchronous to clk (done upstream)
//   btn_left              rotate counter-clockwise (raw, asynchronous)
//   btn_right             rotate clockwise (raw, asynchronous)
//   btn_fire              fire (raw, asynchronous)
//   sw_type               weapon select: 00 none, 01 wide, 10 medium, 11 precise
//   game_over             OR of enemy over flags; blocks new shots
//   hit_angle             current aim sector 0..15
//   shootingtype          weapon type of the most recent shot
//   outgoing_projectiles  one-cycle fire strobe
//   cooldown_active       high while the FSM is in COOLDOWN
//   charges               remaining type-11 shots
//   fire_count            total shots fired, wraps at 16 bits
//   state_dbg             current FSM state (0 idle, 1 fire, 2 cooldown)
//
// All outputs are registered.
// -----------------------------------------------------------------------------

// Two-flop synchronizer followed by a level debouncer. The debounced level
// changes only after the synchronized input has disagreed with it for CYCLES
// consecutive clocks; any agreeing cycle restarts the count.
module pwc_debounce #(
   parameter int unsigned CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);
   localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'((CYCLES > 0) ? CYCLES - 1 : 0);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

module player_weapon_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned ROTATE_REPEAT   = 12500000,
   parameter int unsigned COOLDOWN_WIDE   = 12500000,
   parameter int unsigned COOLDOWN_MED    = 25000000,
   parameter int unsigned COOLDOWN_ULT    = 50000000,
   parameter int unsigned ULT_CHARGES     = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_fire,
   input  logic [1:0]  sw_type,
   input  logic        game_over,
   output logic [3:0]  hit_angle,
   output logic [1:0]  shootingtype,
   output logic        outgoing_projectiles,
   output logic        cooldown_active,
   output logic [1:0]  charges,
   output logic [15:0] fire_count,
   output logic [1:0]  state_dbg
);
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FIRE     = 2'd1,
      ST_COOLDOWN = 2'd2
   } state_t;

   localparam int unsigned CD_MAX_WM = (COOLDOWN_WIDE > COOLDOWN_MED) ? COOLDOWN_WIDE : COOLDOWN_MED;
   localparam int unsigned CD_MAX    = (CD_MAX_WM > COOLDOWN_ULT) ? CD_MAX_WM : COOLDOWN_ULT;
   localparam int unsigned CDW       = (CD_MAX > 0) ? $clog2(CD_MAX + 1) : 1;
   localparam int unsigned RW        = (ROTATE_REPEAT > 1) ? $clog2(ROTATE_REPEAT) : 1;
   localparam logic [RW-1:0] REP_LAST = RW'((ROTATE_REPEAT > 0) ? ROTATE_REPEAT - 1 : 0);
   // Charge register is only two bits wide, so clamp the reset value at 3.
   localparam logic [1:0] CHARGES_INIT = (ULT_CHARGES > 3) ? 2'd3 : 2'(ULT_CHARGES);

   // ---------------------------------------------------------------- inputs
   logic left_lvl, right_lvl, fire_lvl;
   logic left_prev, right_prev, fire_prev;
   logic left_rise, right_rise, fire_rise;

   pwc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_left (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_left),
      .level (left_lvl)
   );

   pwc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_right (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_right),
      .level (right_lvl)
   );

   pwc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_fire),
      .level (fire_lvl)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         left_prev  <= 1'b0;
         right_prev <= 1'b0;
         fire_prev  <= 1'b0;
      end else begin
         left_prev  <= left_lvl;
         right_prev <= right_lvl;
         fire_prev  <= fire_lvl;
      end
   end

   assign left_rise  = left_lvl  & ~left_prev;
   assign right_rise = right_lvl & ~right_prev;
   assign fire_rise  = fire_lvl  & ~fire_prev;

   // ---------------------------------------------------------------- FSM
   state_t           state;
   logic [CDW-1:0]   cd_cnt;
   logic [CDW-1:0]   cd_load;
   logic             fire_go;

   // A shot is taken only from IDLE on a fresh debounced edge, with a weapon
   // selected, the game still running, and a charge left for type 11.
   always_comb begin
      fire_go = 1'b0;
      if (state == ST_IDLE && fire_rise && sw_type != 2'b00 && !game_over &&
          (sw_type != 2'b11 || charges != 2'd0)) begin
         fire_go = 1'b1;
      end
   end

   always_comb begin
      cd_load = '0;
      case (shootingtype)
         2'b01:   cd_load = CDW'(COOLDOWN_WIDE);
         2'b10:   cd_load = CDW'(COOLDOWN_MED);
         2'b11:   cd_load = CDW'(COOLDOWN_ULT);
         default: cd_load = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                <= ST_IDLE;
         cd_cnt               <= '0;
         shootingtype         <= 2'b00;
         outgoing_projectiles <= 1'b0;
         cooldown_active      <= 1'b0;
         charges              <= CHARGES_INIT;
         fire_count           <= 16'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               // Type, count and charges are updated on entry so they are
               // already valid in the strobe cycle.
               if (fire_go) begin
                  state                <= ST_FIRE;
                  outgoing_projectiles <= 1'b1;
                  shootingtype         <= sw_type;
                  fire_count           <= fire_count + 16'd1;
                  if (sw_type == 2'b11 && charges != 2'd0) begin
                     charges <= charges - 2'd1;
                  end
               end
            end
            ST_FIRE: begin
               outgoing_projectiles <= 1'b0;
               cooldown_active      <= 1'b1;
               cd_cnt               <= cd_load;
               state                <= ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
               // Counter runs from the loaded value down to 0 inclusive, so
               // cooldown_active stays high for load+1 cycles.
               if (cd_cnt == '0) begin
                  cooldown_active <= 1'b0;
                  state           <= ST_IDLE;
               end else begin
                  cd_cnt <= cd_cnt - CDW'(1);
               end
            end
            default: begin
               outgoing_projectiles <= 1'b0;
               cooldown_active      <= 1'b0;
               state                <= ST_IDLE;
            end
         endcase
      end
   end

   assign state_dbg = state;

   // ---------------------------------------------------------------- rotation
   logic [RW-1:0] left_cnt, right_cnt;
   logic          both_held;
   logic          step_left, step_right;
   logic          pend_left, pend_right;
   logic [3:0]    angle_next;

   assign both_held  = left_lvl & right_lvl;
   // Step on the edge, then every ROTATE_REPEAT cycles while held alone.
   assign step_right = ~both_held & (right_rise | (right_lvl & (right_cnt == REP_LAST)));
   assign step_left  = ~both_held & (left_rise  | (left_lvl  & (left_cnt  == REP_LAST)));

   always_comb begin
      angle_next = hit_angle + {3'b000, pend_right} - {3'b000, pend_left}
                             + {3'b000, step_right} - {3'b000, step_left};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         left_cnt   <= '0;
         right_cnt  <= '0;
         pend_left  <= 1'b0;
         pend_right <= 1'b0;
         hit_angle  <= 4'd0;
      end else begin
         if (both_held || !right_lvl || step_right) right_cnt <= '0;
         else                                       right_cnt <= right_cnt + RW'(1);
         if (both_held || !left_lvl || step_left)   left_cnt  <= '0;
         else                                       left_cnt  <= left_cnt + RW'(1);

         // A step that would land together with the strobe is parked for one
         // cycle so the angle never changes at the start of a strobe.
         if (fire_go) begin
            pend_right <= step_right;
            pend_left  <= step_left;
         end else begin
            hit_angle  <= angle_next;
            pend_right <= 1'b0;
            pend_left  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_player_weapon_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_weapon_ctrl
//
// Bench for player_weapon_ctrl with small timing parameters. Each cycle the
// DUT outputs are compared with a reference model that works from the raw
// button history and shot timestamps: a debounced level flips once the
// synchronized input has held the opposite value for DEBOUNCE_CYCLES cycles,
// a shot occupies its strobe cycle plus cooldown+1 busy cycles, and a held
// rotate button repeats ROTATE_REPEAT cycles after its last anchor.
// -----------------------------------------------------------------------------
module tb_player_weapon_ctrl;
   localparam int D   = 4;
   localparam int R   = 20;
   localparam int CDW = 10;
   localparam int CDM = 20;
   localparam int CDU = 40;
   localparam int ULT = 2;
   localparam int HMAX = 8192;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        btn_left = 1'b0, btn_right = 1'b0, btn_fire = 1'b0;
   logic [1:0]  sw_type = 2'b00;
   logic        game_over = 1'b0;
   logic [3:0]  hit_angle;
   logic [1:0]  shootingtype;
   logic        outgoing_projectiles;
   logic        cooldown_active;
   logic [1:0]  charges;
   logic [15:0] fire_count;
   logic [1:0]  state_dbg;

   player_weapon_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .ROTATE_REPEAT   (R),
      .COOLDOWN_WIDE   (CDW),
      .COOLDOWN_MED    (CDM),
      .COOLDOWN_ULT    (CDU),
      .ULT_CHARGES     (ULT)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .btn_left             (btn_left),
      .btn_right            (btn_right),
      .btn_fire             (btn_fire),
      .sw_type              (sw_type),
      .game_over            (game_over),
      .hit_angle            (hit_angle),
      .shootingtype         (shootingtype),
      .outgoing_projectiles (outgoing_projectiles),
      .cooldown_active      (cooldown_active),
      .charges              (charges),
      .fire_count           (fire_count),
      .state_dbg            (state_dbg)
   );

   // ------------------------------------------------------------ clock
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "bench timeout");
   end

   // ------------------------------------------------------------ checking
   int total = 0;
   int bad   = 0;
   int t     = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, t);
      end
   endtask

   // ------------------------------------------------------------ model
   bit         hist [0:2][0:HMAX-1];
   bit         deb_l, deb_r, deb_f;
   int         anc_l, anc_r;
   int         exp_angle, exp_type, exp_strobe, exp_cool, exp_charges, exp_count;
   int         pend;
   int         last_s, last_c;
   bit         cur_l, cur_r, cur_f, cur_go;
   logic [1:0] cur_sw;
   int         log_angle[$], log_strobe[$], log_cool[$], log_charges[$], log_type[$];

   function automatic bit raw_at(input int b, input int i);
      if (i < 0 || i >= HMAX) return 1'b0;
      return hist[b][i];
   endfunction

   // Debounced level in cycle tt: the synchronized input in cycle k is the
   // raw input of cycle k-2; flip when the previous D synced values all
   // disagree with the current level.
   function automatic bit deb_next(input int b, input bit prev, input int tt);
      bit all_diff = 1'b1;
      for (int i = 0; i < D; i++) begin
         if (raw_at(b, tt - 3 - i) == prev) all_diff = 1'b0;
      end
      return all_diff ? ~prev : prev;
   endfunction

   function automatic int cooldown_of(input logic [1:0] ty);
      case (ty)
         2'b01:   return CDW;
         2'b10:   return CDM;
         2'b11:   return CDU;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      t = 0;
      deb_l = 0; deb_r = 0; deb_f = 0;
      anc_l = 0; anc_r = 0;
      exp_angle = 0; exp_type = 0; exp_strobe = 0; exp_cool = 0;
      exp_charges = ULT; exp_count = 0;
      pend = 0;
      last_s = -1000; last_c = 0;
      log_angle.delete(); log_strobe.delete(); log_cool.delete();
      log_charges.delete(); log_type.delete();
   endtask

   // Events of cycle t, producing the expected outputs of cycle t+1.
   task automatic model_step();
      bit nl, nr, nf, rl, rr, rf, both, req_l, req_r, idle, accept;
      int step;
      if (t < HMAX) begin
         hist[0][t] = cur_l;
         hist[1][t] = cur_r;
         hist[2][t] = cur_f;
      end
      nl = deb_next(0, deb_l, t);
      nr = deb_next(1, deb_r, t);
      nf = deb_next(2, deb_f, t);
      rl = nl & ~deb_l;
      rr = nr & ~deb_r;
      rf = nf & ~deb_f;
      both  = nl & nr;
      req_r = !both && nr && (rr || (t - anc_r == R));
      req_l = !both && nl && (rl || (t - anc_l == R));
      if (both || rr || req_r) anc_r = t;
      if (both || rl || req_l) anc_l = t;

      idle   = (t > last_s + last_c + 1);
      accept = rf && idle && cur_sw != 2'b00 && !cur_go &&
               (cur_sw != 2'b11 || exp_charges > 0);
      step = int'(req_r) - int'(req_l);
      if (accept) begin
         exp_type  = int'(cur_sw);
         exp_count = (exp_count + 1) % 65536;
         if (cur_sw == 2'b11) exp_charges = exp_charges - 1;
         last_s = t + 1;
         last_c = cooldown_of(cur_sw);
         pend   = step;
      end else begin
         exp_angle = (exp_angle + pend + step + 32) % 16;
         pend      = 0;
      end
      exp_strobe = accept ? 1 : 0;
      exp_cool   = (t + 1 >= last_s + 1 && t + 1 <= last_s + last_c + 1) ? 1 : 0;
      deb_l = nl; deb_r = nr; deb_f = nf;
   endtask

   // ------------------------------------------------------------ drivers
   // Called #1 after the edge that starts cycle t.
   task automatic tick();
      log_angle.push_back(int'(hit_angle));
      log_strobe.push_back(int'(outgoing_projectiles));
      log_cool.push_back(int'(cooldown_active));
      log_charges.push_back(int'(charges));
      log_type.push_back(int'(shootingtype));
      check("angle",   16'(hit_angle),            16'(exp_angle));
      check("type",    16'(shootingtype),         16'(exp_type));
      check("strobe",  16'(outgoing_projectiles), 16'(exp_strobe));
      check("cool",    16'(cooldown_active),      16'(exp_cool));
      check("charges", 16'(charges),              16'(exp_charges));
      check("count",   fire_count,                16'(exp_count));
      btn_left  = cur_l;
      btn_right = cur_r;
      btn_fire  = cur_f;
      sw_type   = cur_sw;
      game_over = cur_go;
      model_step();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic hold(input bit l, input bit r, input bit f, input int n);
      cur_l = l; cur_r = r; cur_f = f;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Asynchronous assertion mid-cycle; outputs must clear before any edge.
   task automatic do_reset();
      cur_l = 0; cur_r = 0; cur_f = 0; cur_go = 0;
      btn_left = 0; btn_right = 0; btn_fire = 0; game_over = 0;
      #2;
      reset = 1'b1;
      #1;
      check("rst_angle",   16'(hit_angle),            16'd0);
      check("rst_type",    16'(shootingtype),         16'd0);
      check("rst_strobe",  16'(outgoing_projectiles), 16'd0);
      check("rst_cool",    16'(cooldown_active),      16'd0);
      check("rst_charges", 16'(charges),              16'(ULT));
      check("rst_count",   fire_count,                16'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic run_random(input int n);
      int hl = 0, hr = 0, hf = 0, hs = 0;
      for (int i = 0; i < n; i++) begin
         if (hl == 0) begin cur_l = ($urandom_range(0, 2) == 0); hl = $urandom_range(1, 40); end
         if (hr == 0) begin cur_r = ($urandom_range(0, 2) == 0); hr = $urandom_range(1, 40); end
         if (hf == 0) begin cur_f = ($urandom_range(0, 1) == 0); hf = $urandom_range(1, 30); end
         if (hs == 0) begin
            cur_sw = 2'($urandom_range(0, 3));
            cur_go = ($urandom_range(0, 9) == 0);
            hs     = $urandom_range(20, 120);
         end
         hl--; hr--; hf--; hs--;
         tick();
      end
   endtask

   // ------------------------------------------------------------ log helpers
   function automatic int count_ones(input int q[$]);
      int n = 0;
      foreach (q[i]) n += (q[i] != 0) ? 1 : 0;
      return n;
   endfunction

   function automatic int first_one(input int q[$]);
      foreach (q[i]) if (q[i] != 0) return i;
      return -1;
   endfunction

   // ------------------------------------------------------------ scenarios
   initial begin
      int fs;
      cur_sw = 2'b00;
      model_reset();

      // 1: single wide shot with fire held, cooldown length.
      do_reset();
      cur_sw = 2'b01;
      hold(0, 0, 1, 30);
      hold(0, 0, 0, 20);
      check("s1_strobes",   16'(count_ones(log_strobe)), 16'd1);
      fs = first_one(log_strobe);
      check("s1_strobe_at", 16'(fs), 16'd7);
      check("s1_type",      16'(log_type[7]), 16'd1);
      check("s1_cool_len",  16'(count_ones(log_cool)), 16'd11);
      check("s1_count",     fire_count, 16'd1);

      // 2: right held with auto-repeat, then a left tap wrapping below 0.
      do_reset();
      hold(0, 1, 0, 50);
      hold(0, 0, 0, 20);
      check("s2_a6",  16'(log_angle[6]),  16'd0);
      check("s2_a7",  16'(log_angle[7]),  16'd1);
      check("s2_a27", 16'(log_angle[27]), 16'd2);
      check("s2_a47", 16'(log_angle[47]), 16'd3);
      check("s2_end", 16'(hit_angle),     16'd3);
      do_reset();
      hold(1, 0, 0, 10);
      hold(0, 0, 0, 15);
      check("s2_left", 16'(hit_angle), 16'd15);

      // 3: precise weapon runs out of charges.
      do_reset();
      cur_sw = 2'b11;
      for (int k = 0; k < 3; k++) begin
         hold(0, 0, 1, 10);
         hold(0, 0, 0, 90);
      end
      check("s3_strobes", 16'(count_ones(log_strobe)), 16'd2);
      check("s3_chg1",    16'(log_charges[7]), 16'd1);
      check("s3_charges", 16'(charges),   16'd0);
      check("s3_count",   fire_count,     16'd2);

      // 4: press during cooldown, no weapon, game over.
      do_reset();
      cur_sw = 2'b10;
      hold(0, 0, 1, 10);
      hold(0, 0, 0, 5);
      hold(0, 0, 1, 8);
      hold(0, 0, 0, 30);
      cur_sw = 2'b00;
      hold(0, 0, 1, 10);
      hold(0, 0, 0, 10);
      cur_sw = 2'b01;
      cur_go = 1'b1;
      hold(0, 0, 1, 10);
      hold(0, 0, 0, 10);
      cur_go = 1'b0;
      check("s4_strobes", 16'(count_ones(log_strobe)), 16'd1);
      check("s4_count",   fire_count, 16'd1);

      // 5: rotation coinciding with the strobe, then both buttons together.
      do_reset();
      cur_sw = 2'b01;
      hold(0, 1, 1, 10);
      hold(0, 0, 0, 30);
      check("s5_strobe7", 16'(log_strobe[7]), 16'd1);
      check("s5_a7",      16'(log_angle[7]),  16'd0);
      check("s5_a8",      16'(log_angle[8]),  16'd1);
      hold(1, 1, 0, 30);
      hold(0, 0, 0, 20);
      check("s5_both", 16'(hit_angle), 16'd1);

      // 6: reset in the middle of a precise-weapon cooldown.
      do_reset();
      cur_sw = 2'b11;
      for (int k = 0; k < 5; k++) begin
         hold(0, 1, 0, 10);
         hold(0, 0, 0, 10);
      end
      check("s6_angle", 16'(hit_angle), 16'd5);
      hold(0, 0, 1, 10);
      hold(0, 0, 0, 20);
      check("s6_cool",    16'(cooldown_active), 16'd1);
      check("s6_charges", 16'(charges),         16'd1);
      do_reset();
      hold(0, 0, 0, 10);
      hold(0, 0, 1, 10);
      hold(0, 0, 0, 10);
      fs = first_one(log_strobe);
      check("s6_strobe_at", 16'(fs), 16'd17);
      if (fs >= 0) check("s6_chg_at_strobe", 16'(log_charges[fs]), 16'd1);

      // Randomized stretches against the model.
      for (int s = 0; s < 6; s++) begin
         do_reset();
         run_random(500);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/player_weapon_ctrl.md
# player_weapon_ctrl

Player-side weapon controller: the transmitting end of the projectile interface that each enemy block consumes. It turns the rotate/fire push-buttons and the weapon-select switches into a 16-direction aim angle (`hit_angle`), a latched weapon type (`shootingtype`) and a single-cycle `outgoing_projectiles` pulse. It enforces per-weapon cooldown and a limited charge count for the precise weapon. It sits between the board I/O (keys/switches) and the enemy instances, which are driven in parallel.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles needed to accept a button level change.
- `ROTATE_REPEAT`, 12500000: auto-repeat period, in cycles, while a rotate button is held.
- `COOLDOWN_WIDE`, 12500000: cooldown after a type-01 shot.
- `COOLDOWN_MED`, 25000000: cooldown after a type-10 shot.
- `COOLDOWN_ULT`, 50000000: cooldown after a type-11 shot.
- `ULT_CHARGES`, 3: type-11 shots available after reset (max 3).

- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `btn_left`  in  1: rotate counter-clockwise; active-high; asynchronous to `clk`.
- `btn_right`  in  1: rotate clockwise; active-high; asynchronous.
- `btn_fire`  in  1: fire; active-high; asynchronous.
- `sw_type`  in  2: weapon select. 00 = none, 01 = wide, 10 = medium, 11 = precise.
- `game_over`  in  1: OR of enemy `over` flags; inhibits firing.
- `hit_angle`  out  4: current aim sector, 0–15.
- `shootingtype`  out  2: weapon type of the most recent shot.
- `outgoing_projectiles`  out  1: one-cycle fire strobe.
- `cooldown_active`  out  1: high while in COOLDOWN.
- `charges`  out  2: remaining type-11 shots.
- `fire_count`  out  16: total shots fired; wraps.

## Operation
- **Input conditioning.** Each button passes through a 2-FF synchronizer, then a debouncer. The debounced level flips only after the synced level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Rising edge = debounced level now 1, previous 0.
- **Rotation.**
  - Right edge: `hit_angle` +1 mod 16 (15→0).
  - Left edge: `hit_angle` −1 mod 16 (0→15).
  - While one button stays debounced-high, repeat the step every `ROTATE_REPEAT` cycles after the edge.
  - Both debounced-high: no step, and the repeat counters are held at 0.
- **Rotation vs. fire.** A rotation step falling in a cycle where `outgoing_projectiles`=1 sets a pending bit and is applied on the next cycle. `hit_angle` is therefore stable during every strobe.
- **FSM states:** IDLE, FIRE, COOLDOWN.
  - **IDLE → FIRE:** requires a fire rising edge, `sw_type`≠00, `game_over`=0, and (`sw_type`≠11 or `charges`>0).
    - Latch `sw_type` into `shootingtype`.
    - If type 11, decrement `charges`.
    - Increment `fire_count` (65535→0).
  - **Rejected fire edge:** any other fire edge in IDLE is discarded. Nothing changes.
  - **FIRE:** `outgoing_projectiles`=1 for exactly this one cycle. Load the cooldown counter with the `COOLDOWN_*` value for the latched type, then go to COOLDOWN.
  - **COOLDOWN:** `cooldown_active`=1. Counter decrements each cycle; at 0 return to IDLE. Fire edges here are ignored, not queued. Rotation is still allowed.
- **No auto-fire.** Holding fire fires only once; a new rising edge is required.
- **Live inputs.** `sw_type` and `game_over` changes during COOLDOWN do not affect the cooldown already loaded. `game_over` rising does not abort a cooldown.
- **Charges.** `charges` saturates at 0. It is refilled only by reset.

## Timing
- **Reset values (async assert, sync release):** `hit_angle`=0, `shootingtype`=00, `outgoing_projectiles`=0, `cooldown_active`=0, `charges`=`ULT_CHARGES`, `fire_count`=0, FSM=IDLE. Debouncers, repeat counters and the pending bit are cleared. Reset mid-COOLDOWN or mid-FIRE aborts immediately.
- **Fire latency:** raw `btn_fire` high and held from cycle 0 gives `outgoing_projectiles`=1 in cycle `DEBOUNCE_CYCLES`+3.
- **Rotation latency:** same as fire; `hit_angle` updates in cycle `DEBOUNCE_CYCLES`+3.
- **Outputs in the strobe cycle:** `shootingtype`, `fire_count` and `charges` show their updated values in the same cycle the strobe is high.
- **Cooldown length:** `cooldown_active` is high for exactly `COOLDOWN_x`+1 cycles, starting the cycle after the strobe.
- **Next shot:** the earliest next strobe is the cycle after IDLE is re-entered plus one, i.e. edge detect → FIRE.
- **Register outputs:** all outputs are registered; there is no combinational path from the inputs.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `ROTATE_REPEAT`=20, cooldowns 10/20/40, `ULT_CHARGES`=2.

1. Reset, `sw_type`=01, fire held 30 cycles → exactly one strobe at cycle 7 with `shootingtype`=01. `cooldown_active` high for 11 cycles. `fire_count`=1.
2. Right held 50 cycles from `hit_angle`=0 → steps at cycles 7, 27, 47, ending at 3. Then a left tap (held 10) from 0 → 15.
3. `sw_type`=11, three separate fire presses spaced 100 cycles → two strobes, `charges` 2→1→0. Third press: no strobe, `fire_count`=2.
4. `sw_type`=10, fire press during COOLDOWN → no extra strobe. `sw_type`=00 or `game_over`=1 → fire press gives no strobe.
5. Right edge timed to land in the strobe cycle → `hit_angle` unchanged during the strobe, +1 the next cycle. Left and right pressed together → no change.
6. Reset asserted mid-COOLDOWN with `hit_angle`=5 and `charges`=1 → all outputs at reset values immediately. A fire press 10 cycles after release → strobe with `charges`=2→1 if `sw_type`=11.
